// File: rtl/sprite_layer_db.sv
// sprite_layer_db: double-buffered sprite layer that decodes commands, swaps banks at a frame boundary and
// drives a 3-stage composited pixel pipeline with hflip, transparency and child-index priority.
module sprite_layer_db #(
  parameter logic [5:0] COMPONENT_ID = 6'b001001,
  parameter int NUM_CHILDREN = 4,
  parameter int NUM_PATTERNS = 4,
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int PIX_BITS = 2,
  parameter logic [9:0] V_SWAP = 10'd480,
  parameter string ROM_FILE = "sprite.txt"
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [23:0] RGB_output,
  output logic        pixel_valid,
  output logic        swap_pending
);
  localparam int CB = $clog2(SPR_W);
  localparam int RB = $clog2(SPR_H);
  localparam int AW = 5 + RB + CB;

  // Pattern image: index = (pattern + row + col + 1) mod 2**PIX_BITS, so index 0 marks transparent pixels
  function automatic logic [PIX_BITS-1:0] rom_pix(input logic [AW-1:0] a);
    return PIX_BITS'(32'(a[AW-1:RB+CB]) + 32'(a[RB+CB-1:CB]) + 32'(a[CB-1:0]) + 1);
  endfunction

  function automatic logic [23:0] palette(input logic [PIX_BITS-1:0] i);
    return i == '0 ? 24'h202020 : 24'(32'(i) * 32'h405060);
  endfunction

  logic [5:0]  comp;
  logic [4:0]  child;
  logic [3:0]  ctrl;
  logic [2:0]  typ;
  logic [12:0] payload;
  logic        unused;
  assign comp    = writedata[31:26];
  assign child   = writedata[25:21];
  assign ctrl    = writedata[20:17];
  assign typ     = writedata[16:14];
  assign payload = writedata[12:0];
  assign unused  = &{1'b0, writedata[13], payload[10]};

  logic [NUM_CHILDREN-1:0] vis_q [2], vis_d [2], hf_q [2], hf_d [2];
  logic [9:0] x_q [2][NUM_CHILDREN], x_d [2][NUM_CHILDREN];
  logic [9:0] y_q [2][NUM_CHILDREN], y_d [2][NUM_CHILDREN];
  logic [4:0] pat_q [2][NUM_CHILDREN], pat_d [2][NUM_CHILDREN];
  logic front_q, front_d, swap_q, swap_d, back, commit, cfg_wr, pat_bad;

  assign back    = ~front_q;
  assign commit  = swap_q && hcount == 10'd0 && vcount == V_SWAP;
  assign cfg_wr  = write && ctrl == 4'h1 && comp == COMPONENT_ID;
  assign pat_bad = 32'(payload[4:0]) >= NUM_PATTERNS;

  // The copy into the new back bank takes precedence over any config write in the commit cycle
  always_comb begin
    vis_d = vis_q;
    hf_d = hf_q;
    x_d = x_q;
    y_d = y_q;
    pat_d = pat_q;
    front_d = front_q;
    swap_d = swap_q;
    if (commit) begin
      front_d = back;
      vis_d[front_q] = vis_q[back];
      hf_d[front_q] = hf_q[back];
      x_d[front_q] = x_q[back];
      y_d[front_q] = y_q[back];
      pat_d[front_q] = pat_q[back];
      swap_d = 1'b0;
    end else if (cfg_wr) begin
      for (int i = 0; i < NUM_CHILDREN; i++) begin
        if (5'(i) == child) begin
          if (typ == 3'b000 && !pat_bad) begin
            vis_d[back][i] = payload[12];
            hf_d[back][i] = payload[11];
            pat_d[back][i] = payload[4:0];
          end
          if (typ == 3'b001) x_d[back][i] = payload[9:0];
          if (typ == 3'b010) y_d[back][i] = payload[9:0];
        end
      end
    end
    if (write && ctrl == 4'hF) swap_d = 1'b1;
  end

  logic [NUM_CHILDREN-1:0] hit0_d, hit0_q, hit1_q;
  logic [AW-1:0] addr0_d [NUM_CHILDREN], addr0_q [NUM_CHILDREN];
  logic [PIX_BITS-1:0] pix1_d [NUM_CHILDREN], pix1_q [NUM_CHILDREN];
  logic [23:0] rgb_d, rgb_q;
  logic valid_d, valid_q;

  // Bounds use 11-bit sums so a sprite near column/row 1023 never wraps to the left/top edge
  always_comb begin
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      hit0_d[i] = vis_q[front_q][i]
        && {1'b0, hcount} >= {1'b0, x_q[front_q][i]} && {1'b0, hcount} < {1'b0, x_q[front_q][i]} + 11'(SPR_W)
        && {1'b0, vcount} >= {1'b0, y_q[front_q][i]} && {1'b0, vcount} < {1'b0, y_q[front_q][i]} + 11'(SPR_H);
      addr0_d[i] = {pat_q[front_q][i], RB'(vcount - y_q[front_q][i]),
                    CB'(hcount - x_q[front_q][i]) ^ {CB{hf_q[front_q][i]}}};
      pix1_d[i] = rom_pix(addr0_q[i]);
    end
  end

  always_comb begin
    rgb_d = palette('0);
    valid_d = 1'b0;
    for (int i = NUM_CHILDREN - 1; i >= 0; i--) begin
      if (hit1_q[i] && pix1_q[i] != '0) begin
        rgb_d = palette(pix1_q[i]);
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vis_q <= '{default: '0};
      hf_q <= '{default: '0};
      x_q <= '{default: '0};
      y_q <= '{default: '0};
      pat_q <= '{default: '0};
      front_q <= 1'b0;
      swap_q <= 1'b0;
      hit0_q <= '0;
      hit1_q <= '0;
      addr0_q <= '{default: '0};
      pix1_q <= '{default: '0};
      rgb_q <= 24'h202020;
      valid_q <= 1'b0;
    end else begin
      vis_q <= vis_d;
      hf_q <= hf_d;
      x_q <= x_d;
      y_q <= y_d;
      pat_q <= pat_d;
      front_q <= front_d;
      swap_q <= swap_d;
      hit0_q <= hit0_d;
      hit1_q <= hit0_q;
      addr0_q <= addr0_d;
      pix1_q <= pix1_d;
      rgb_q <= rgb_d;
      valid_q <= valid_d;
    end
  end

  assign RGB_output = rgb_q;
  assign pixel_valid = valid_q;
  assign swap_pending = swap_q;
endmodule

// File: tb/tb_sprite_layer_db.sv
// tb_sprite_layer_db: directed scenarios for the double-buffered sprite layer.
// Pattern pixel = (pattern+row+col+1) mod 4; palette 0:202020 1:405060 2:80A0C0 3:C0F120.
module tb_sprite_layer_db;
  localparam logic [5:0] ID = 6'b001001;
  localparam logic [23:0] P0 = 24'h202020, P1 = 24'h405060, P2 = 24'h80A0C0, P3 = 24'hC0F120;

  logic clk = 1'b0, reset_n = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0;
  logic [9:0] hcount = 10'd5, vcount = 10'd0;
  logic [23:0] RGB_output, rgb;
  logic pixel_valid, swap_pending, vld;
  int checks = 0, fails = 0;

  sprite_layer_db dut (
    .clk(clk), .reset_n(reset_n), .write(write), .writedata(writedata),
    .hcount(hcount), .vcount(vcount), .RGB_output(RGB_output),
    .pixel_valid(pixel_valid), .swap_pending(swap_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cmd(input logic [5:0] comp, input logic [4:0] ch, input logic [3:0] ctrl,
                                      input logic [2:0] ty, input logic [12:0] pl);
    return {comp, ch, ctrl, ty, 1'b0, pl};
  endfunction

  task automatic wr(input logic [31:0] w);
    writedata = w;
    write = 1'b1;
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic commit(input logic en, input logic [31:0] w);
    hcount = 10'd0;
    vcount = 10'd480;
    write = en;
    writedata = w;
    @(posedge clk);
    #1 write = 1'b0;
    hcount = 10'd5;
    vcount = 10'd0;
  endtask

  task automatic probe(input logic [9:0] h, input logic [9:0] v);
    hcount = h;
    vcount = v;
    repeat (3) @(posedge clk);
    #1 rgb = RGB_output;
    vld = pixel_valid;
  endtask

  task automatic place(input logic [4:0] ch, input logic [12:0] attr, input logic [9:0] x, input logic [9:0] y);
    wr(cmd(ID, ch, 4'h1, 3'b000, attr));
    wr(cmd(ID, ch, 4'h1, 3'b001, {3'b0, x}));
    wr(cmd(ID, ch, 4'h1, 3'b010, {3'b0, y}));
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (RGB_output !== P0 || pixel_valid !== 1'b0 || swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: rgb=%h valid=%b pend=%b, want %h 0 0", RGB_output, pixel_valid, swap_pending, P0);
    end
    reset_n = 1'b1;
    probe(10'd0, 10'd0);
    checks++;
    if (rgb !== P0 || vld !== 1'b0) begin
      fails++;
      $display("FAIL reset_blank: rgb=%h valid=%b, want %h 0", rgb, vld, P0);
    end
  endtask

  task automatic test_basic();
    place(5'd0, 13'h1000, 10'd100, 10'd50);
    wr(cmd(6'h00, 5'd7, 4'hF, 3'b000, 13'h0));
    checks++;
    if (swap_pending !== 1'b1) begin
      fails++;
      $display("FAIL basic_pending: got %b want 1", swap_pending);
    end
    probe(10'd100, 10'd50);
    checks++;
    if (rgb !== P0 || vld !== 1'b0) begin
      fails++;
      $display("FAIL basic_precommit: rgb=%h valid=%b, want %h 0", rgb, vld, P0);
    end
    commit(1'b0, '0);
    checks++;
    if (swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL basic_commit: pend=%b want 0", swap_pending);
    end
    probe(10'd99, 10'd50);
    hcount = 10'd100;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pixel_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_latency2: valid=%b want 0", pixel_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (RGB_output !== P1 || pixel_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_latency3: rgb=%h valid=%b, want %h 1", RGB_output, pixel_valid, P1);
    end
    probe(10'd115, 10'd65);
    checks++;
    if (rgb !== P3 || vld !== 1'b1) begin
      fails++;
      $display("FAIL basic_corner: rgb=%h valid=%b, want %h 1", rgb, vld, P3);
    end
    probe(10'd116, 10'd50);
    checks++;
    if (vld !== 1'b0) begin
      fails++;
      $display("FAIL basic_right_edge: valid=%b want 0", vld);
    end
  endtask

  task automatic test_priority();
    place(5'd1, 13'h1002, 10'd100, 10'd50);
    wr(cmd(ID, 5'd0, 4'hF, 3'b000, 13'h0));
    commit(1'b0, '0);
    probe(10'd100, 10'd50);
    checks++;
    if (rgb !== P1 || vld !== 1'b1) begin
      fails++;
      $display("FAIL prio_child0: rgb=%h valid=%b, want %h 1", rgb, vld, P1);
    end
    probe(10'd103, 10'd50);
    checks++;
    if (rgb !== P2 || vld !== 1'b1) begin
      fails++;
      $display("FAIL prio_transparent: rgb=%h valid=%b, want %h 1", rgb, vld, P2);
    end
  endtask

  task automatic test_hflip();
    place(5'd2, 13'h1800, 10'd200, 10'd100);
    wr(cmd(ID, 5'd0, 4'hF, 3'b000, 13'h0));
    commit(1'b0, '0);
    probe(10'd200, 10'd101);
    checks++;
    if (rgb !== P1 || vld !== 1'b1) begin
      fails++;
      $display("FAIL hflip_left: rgb=%h valid=%b, want %h 1", rgb, vld, P1);
    end
    probe(10'd215, 10'd101);
    checks++;
    if (rgb !== P2 || vld !== 1'b1) begin
      fails++;
      $display("FAIL hflip_right: rgb=%h valid=%b, want %h 1", rgb, vld, P2);
    end
    probe(10'd216, 10'd101);
    checks++;
    if (rgb !== P0 || vld !== 1'b0) begin
      fails++;
      $display("FAIL hflip_outside: rgb=%h valid=%b, want %h 0", rgb, vld, P0);
    end
  endtask

  task automatic test_edge();
    place(5'd3, 13'h1000, 10'd1020, 10'd300);
    wr(cmd(ID, 5'd3, 4'h1, 3'b000, 13'h1804));
    wr(cmd(ID, 5'd0, 4'hF, 3'b000, 13'h0));
    commit(1'b0, '0);
    probe(10'd1020, 10'd301);
    checks++;
    if (rgb !== P2 || vld !== 1'b1) begin
      fails++;
      $display("FAIL edge_1020_dropped_write: rgb=%h valid=%b, want %h 1", rgb, vld, P2);
    end
    probe(10'd1023, 10'd301);
    checks++;
    if (rgb !== P1 || vld !== 1'b1) begin
      fails++;
      $display("FAIL edge_1023: rgb=%h valid=%b, want %h 1", rgb, vld, P1);
    end
    probe(10'd0, 10'd301);
    checks++;
    if (vld !== 1'b0) begin
      fails++;
      $display("FAIL edge_nowrap_0: valid=%b want 0", vld);
    end
    probe(10'd11, 10'd301);
    checks++;
    if (vld !== 1'b0) begin
      fails++;
      $display("FAIL edge_nowrap_11: valid=%b want 0", vld);
    end
  endtask

  task automatic test_double_buffer();
    wr(cmd(ID, 5'd3, 4'h1, 3'b001, 13'd500));
    wr(cmd(6'h02, 5'd3, 4'h1, 3'b001, 13'd700));
    probe(10'd1020, 10'd301);
    checks++;
    if (rgb !== P2 || vld !== 1'b1) begin
      fails++;
      $display("FAIL dbuf_no_tear: rgb=%h valid=%b, want %h 1", rgb, vld, P2);
    end
    wr(cmd(ID, 5'd0, 4'hF, 3'b000, 13'h0));
    wr(cmd(ID, 5'd0, 4'hF, 3'b000, 13'h0));
    checks++;
    if (swap_pending !== 1'b1) begin
      fails++;
      $display("FAIL dbuf_pending: pend=%b want 1", swap_pending);
    end
    commit(1'b0, '0);
    checks++;
    if (swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL dbuf_single_swap: pend=%b want 0", swap_pending);
    end
    probe(10'd500, 10'd301);
    checks++;
    if (rgb !== P2 || vld !== 1'b1) begin
      fails++;
      $display("FAIL dbuf_new_x: rgb=%h valid=%b, want %h 1", rgb, vld, P2);
    end
    probe(10'd1020, 10'd301);
    checks++;
    if (vld !== 1'b0) begin
      fails++;
      $display("FAIL dbuf_old_x: valid=%b want 0", vld);
    end
    probe(10'd700, 10'd301);
    checks++;
    if (vld !== 1'b0) begin
      fails++;
      $display("FAIL dbuf_foreign_comp: valid=%b want 0", vld);
    end
    commit(1'b0, '0);
    checks++;
    if (swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL dbuf_idle_commit: pend=%b want 0", swap_pending);
    end
  endtask

  task automatic test_back_to_back();
    wr(cmd(ID, 5'd0, 4'hF, 3'b000, 13'h0));
    commit(1'b1, cmd(ID, 5'd3, 4'h1, 3'b001, 13'd600));
    wr(cmd(ID, 5'd0, 4'hF, 3'b000, 13'h0));
    commit(1'b0, '0);
    probe(10'd500, 10'd301);
    checks++;
    if (rgb !== P2 || vld !== 1'b1) begin
      fails++;
      $display("FAIL b2b_write_lost_keep: rgb=%h valid=%b, want %h 1", rgb, vld, P2);
    end
    probe(10'd600, 10'd301);
    checks++;
    if (vld !== 1'b0) begin
      fails++;
      $display("FAIL b2b_write_lost_new: valid=%b want 0", vld);
    end
    wr(cmd(ID, 5'd0, 4'hF, 3'b000, 13'h0));
    commit(1'b1, cmd(6'h00, 5'd0, 4'hF, 3'b000, 13'h0));
    checks++;
    if (swap_pending !== 1'b1) begin
      fails++;
      $display("FAIL b2b_rearm: pend=%b want 1", swap_pending);
    end
  endtask

  task automatic test_reset_mid();
    probe(10'd100, 10'd50);
    checks++;
    if (rgb !== P1 || vld !== 1'b1 || swap_pending !== 1'b1) begin
      fails++;
      $display("FAIL midreset_pre: rgb=%h valid=%b pend=%b, want %h 1 1", rgb, vld, swap_pending, P1);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (RGB_output !== P0 || pixel_valid !== 1'b0 || swap_pending !== 1'b0) begin
      fails++;
      $display("FAIL midreset_async: rgb=%h valid=%b pend=%b, want %h 0 0", RGB_output, pixel_valid, swap_pending, P0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    probe(10'd100, 10'd50);
    checks++;
    if (rgb !== P0 || vld !== 1'b0) begin
      fails++;
      $display("FAIL midreset_cleared: rgb=%h valid=%b, want %h 0", rgb, vld, P0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_hflip();
    test_edge();
    test_double_buffer();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
